// File: rtl/rx_dll_pkg.sv
// Shared types and constants for the receive-side data link layer.
// Frame field positions, DLLP encodings and the DLLP FSM states.
package rx_dll_pkg;

    localparam int DATA_W  = 1024;
    localparam int SEQ_W   = 12;
    localparam int SEQ_HI  = 1019;
    localparam int SEQ_LO  = 1008;
    localparam int LCRC_W  = 32;

    localparam logic [7:0] DLLP_ACK = 8'h00;
    localparam logic [7:0] DLLP_NAK = 8'h10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_NAK
    } dllp_state_t;

    function automatic logic [31:0] make_dllp(
        input logic [7:0]       typ,
        input logic [SEQ_W-1:0] seq
    );
        return {typ, 12'h000, seq};
    endfunction

endpackage

// File: rtl/rx_dll_ack_nak_if.sv
// Link-side bundle: TLP stream in, good TLPs out, ACK/NAK DLLPs out.
// master drives the stimulus side, slave is the data link layer.
interface rx_dll_ack_nak_if;
    import rx_dll_pkg::*;

    logic [DATA_W-1:0] tlp_in_data;
    logic              tlp_in_valid;
    logic              tlp_in_ready;
    logic [DATA_W-1:0] tlp_out_data;
    logic              tlp_out_valid;
    logic              tlp_out_ready;
    logic [31:0]       dllp_o;
    logic              dllp_valid_o;
    logic              dllp_ready_i;
    logic [15:0]       lcrc_err_cnt;

    modport master (
        output tlp_in_data, tlp_in_valid, tlp_out_ready, dllp_ready_i,
        input  tlp_in_ready, tlp_out_data, tlp_out_valid,
        input  dllp_o, dllp_valid_o, lcrc_err_cnt
    );

    modport slave (
        input  tlp_in_data, tlp_in_valid, tlp_out_ready, dllp_ready_i,
        output tlp_in_ready, tlp_out_data, tlp_out_valid,
        output dllp_o, dllp_valid_o, lcrc_err_cnt
    );

endinterface

// File: rtl/rx_lcrc_check.sv
// LCRC check: XOR-fold of the 31 upper 32-bit words against the
// low word of the frame.
module rx_lcrc_check
    import rx_dll_pkg::*;
(
    input  logic [DATA_W-1:0] i_frame,
    output logic              o_lcrc_ok
);

    logic [LCRC_W-1:0] w_fold;

    // Fold every word above the LCRC field into one 32-bit value
    always_comb begin
        w_fold = '0;
        for (int i = 1; i < DATA_W / LCRC_W; i++) begin
            w_fold = w_fold ^ i_frame[i*LCRC_W +: LCRC_W];
        end
    end

    assign o_lcrc_ok = (w_fold == i_frame[LCRC_W-1:0]);

endmodule

// File: rtl/rx_dll_ack_nak.sv
// RX data link layer: LCRC/sequence checking, in-order forwarding,
// ACK coalescing/timeout and NAK scheduling onto a DLLP handshake.
module rx_dll_ack_nak
    import rx_dll_pkg::*;
#(
    parameter int ACK_LATENCY  = 64,
    parameter int ACK_COALESCE = 4
) (
    input  logic           clk,
    input  logic           reset_n,
    rx_dll_ack_nak_if.slave bus
);

    localparam int TMR_W = $clog2(ACK_LATENCY) + 1;
    localparam int CNT_W = $clog2(ACK_COALESCE) + 1;

    logic              w_lcrc_ok;
    logic              w_accept;
    logic              w_good;
    logic              w_ahead;
    logic              w_dup;
    logic              w_bad;
    logic              w_nak_evt;
    logic              w_hs;
    logic              w_ack_done;
    logic              w_nak_done;
    logic              w_ack_due;
    logic [SEQ_W-1:0]  w_seq;
    logic [SEQ_W-1:0]  w_dist;
    dllp_state_t       w_state_nxt;

    dllp_state_t       r_state;
    logic [SEQ_W-1:0]  r_next_seq;
    logic              r_nak_sched;
    logic              r_nak_pend;
    logic              r_ack_pend;
    logic [TMR_W-1:0]  r_timer;
    logic [CNT_W-1:0]  r_coal;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_valid;
    logic [15:0]       r_err_cnt;
    logic [31:0]       r_dllp;

    rx_lcrc_check u_lcrc (
        .i_frame   (bus.tlp_in_data),
        .o_lcrc_ok (w_lcrc_ok)
    );

    assign bus.tlp_in_ready  = !r_out_valid | bus.tlp_out_ready;
    assign bus.tlp_out_data  = r_out_data;
    assign bus.tlp_out_valid = r_out_valid;
    assign bus.dllp_o        = r_dllp;
    assign bus.dllp_valid_o  = (r_state != S_IDLE);
    assign bus.lcrc_err_cnt  = r_err_cnt;

    assign w_accept = bus.tlp_in_valid & bus.tlp_in_ready;
    assign w_seq    = bus.tlp_in_data[SEQ_HI:SEQ_LO];
    assign w_dist   = w_seq - r_next_seq;
    assign w_bad    = w_accept & !w_lcrc_ok;
    assign w_good   = w_accept & w_lcrc_ok & (w_dist == '0);
    assign w_ahead  = w_accept & w_lcrc_ok & (w_dist != '0) & !w_dist[SEQ_W-1];
    assign w_dup    = w_accept & w_lcrc_ok & w_dist[SEQ_W-1];

    // Only the first error after a good TLP schedules a NAK
    assign w_nak_evt  = (w_bad | w_ahead) & !r_nak_sched;
    assign w_hs       = (r_state != S_IDLE) & bus.dllp_ready_i;
    assign w_ack_done = (r_state == S_ACK) & bus.dllp_ready_i;
    assign w_nak_done = (r_state == S_NAK) & bus.dllp_ready_i;
    assign w_ack_due  = (r_timer >= TMR_W'(ACK_LATENCY - 1))
                      | (r_coal >= CNT_W'(ACK_COALESCE));

    // Forward in-order good frames through a single output register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_good) begin
            r_out_data  <= bus.tlp_in_data;
            r_out_valid <= 1'b1;
        end else if (bus.tlp_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Sequence tracking, NAK scheduling and LCRC error counting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_next_seq  <= '0;
            r_nak_sched <= 1'b0;
            r_nak_pend  <= 1'b0;
            r_ack_pend  <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            if (w_good) begin
                r_next_seq  <= r_next_seq + 1'b1;
                r_nak_sched <= 1'b0;
            end else if (w_nak_evt) begin
                r_nak_sched <= 1'b1;
            end
            r_nak_pend <= (r_nak_pend & !w_nak_done) | w_nak_evt;
            r_ack_pend <= (r_ack_pend & !w_hs) | w_good | w_dup;
            if (w_bad && r_err_cnt != 16'hFFFF) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    // ACK timeout timer and coalescing counter, both cleared by an ACK
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_timer <= '0;
            r_coal  <= '0;
        end else begin
            if (w_ack_done) begin
                r_timer <= '0;
            end else if (r_ack_pend && r_state == S_IDLE && r_timer != '1) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_ack_done) begin
                r_coal <= w_good ? CNT_W'(1) : '0;
            end else if (w_good && r_coal != '1) begin
                r_coal <= r_coal + 1'b1;
            end
        end
    end

    // DLLP FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // DLLP FSM next state: NAK wins over ACK
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (r_nak_pend) w_state_nxt = S_NAK;
                else if (r_ack_pend && w_ack_due) w_state_nxt = S_ACK;
            end
            S_ACK, S_NAK: begin
                if (bus.dllp_ready_i) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Capture the DLLP on entry so it stays stable until the handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dllp <= '0;
        end else if (r_state == S_IDLE && w_state_nxt != S_IDLE) begin
            r_dllp <= make_dllp((w_state_nxt == S_NAK) ? DLLP_NAK : DLLP_ACK,
                                r_next_seq - 1'b1);
        end
    end

endmodule

// File: tb/tb_rx_dll_ack_nak.sv
// Directed bench for rx_dll_ack_nak with TLP and DLLP scoreboards.
// Expected frames/DLLPs are queued at stimulus time, popped on output.
module tb_rx_dll_ack_nak;

    localparam int DW = 1024;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    rx_dll_ack_nak_if bus ();

    rx_dll_ack_nak #(
        .ACK_LATENCY  (64),
        .ACK_COALESCE (4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int acc_cyc = 0;
    int n_dllp = 0;
    bit wrap_mode = 1'b0;
    bit held_v = 1'b0;
    bit prev_v = 1'b0;
    logic [31:0] held;
    logic [31:0] m_dllp;
    logic [DW-1:0] m_tlp;
    logic [DW-1:0] exp_tlp[$];
    logic [31:0] exp_dllp[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dl(input bit nak, input int seq);
        logic [31:0] d;
        d = '0;
        d[31:24] = nak ? 8'h10 : 8'h00;
        d[11:0] = seq[11:0];
        return d;
    endfunction

    function automatic logic [DW-1:0] mk(input int seq, input bit bad);
        logic [DW-1:0] f;
        logic [31:0] x;
        f = '0;
        for (int i = 1; i < 32; i++) f[i*32 +: 32] = $urandom;
        f[1023:1020] = 4'h0;
        f[1019:1008] = seq[11:0];
        x = '0;
        for (int i = 1; i < 32; i++) x = x ^ f[i*32 +: 32];
        f[31:0] = bad ? ~x : x;
        return f;
    endfunction

    // TLP output scoreboard
    always @(negedge clk) begin
        if (reset_n && bus.tlp_out_valid && bus.tlp_out_ready) begin
            m_tlp = exp_tlp.size() ? exp_tlp.pop_front() : 'x;
            n_chk++;
            assert (bus.tlp_out_data === m_tlp) else begin
                n_fail++;
                $error("FAIL tlp_out seq observed=%0h expected=%0h",
                       bus.tlp_out_data[1019:1008], m_tlp[1019:1008]);
            end
        end
    end

    // DLLP scoreboard plus hold/stability checks while not accepted
    always @(negedge clk) begin
        if (!reset_n) begin
            held_v = 1'b0;
            prev_v = 1'b0;
        end else begin
            if (bus.dllp_valid_o && !prev_v) rise_cyc = cyc;
            if (held_v) begin
                chk("dllp_hold_valid", 32'(bus.dllp_valid_o), 1);
                chk("dllp_hold_stable", bus.dllp_o, held);
            end
            if (bus.dllp_valid_o && bus.dllp_ready_i) begin
                n_dllp++;
                if (wrap_mode) begin
                    chk("wrap_ack_type", 32'(bus.dllp_o[31:24]), 0);
                end else begin
                    m_dllp = exp_dllp.size() ? exp_dllp.pop_front() : 'x;
                    chk("dllp", bus.dllp_o, m_dllp);
                end
                held_v = 1'b0;
            end else if (bus.dllp_valid_o) begin
                held = bus.dllp_o;
                held_v = 1'b1;
            end else begin
                held_v = 1'b0;
            end
            prev_v = bus.dllp_valid_o;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_out_ready(input bit v);
        @(posedge clk);
        #1 bus.tlp_out_ready = v;
    endtask

    task automatic set_dllp_ready(input bit v);
        @(posedge clk);
        #1 bus.dllp_ready_i = v;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.tlp_in_valid = 1'b0;
        bus.tlp_in_data = '0;
        bus.tlp_out_ready = 1'b1;
        bus.dllp_ready_i = 1'b1;
        exp_tlp.delete();
        exp_dllp.delete();
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(bus.tlp_out_valid), 0);
        chk("rst_out_data", 32'(|bus.tlp_out_data), 0);
        chk("rst_dllp_valid", 32'(bus.dllp_valid_o), 0);
        chk("rst_dllp", bus.dllp_o, 0);
        chk("rst_err_cnt", 32'(bus.lcrc_err_cnt), 0);
        chk("rst_in_ready", 32'(bus.tlp_in_ready), 1);
        reset_n = 1'b1;
        idle(2);
    endtask

    task automatic send(input int seq, input bit bad, input bit fwd);
        int n;
        logic [DW-1:0] f;
        f = mk(seq, bad);
        if (fwd) exp_tlp.push_back(f);
        @(negedge clk);
        bus.tlp_in_data = f;
        bus.tlp_in_valid = 1'b1;
        n = 0;
        while (!bus.tlp_in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("send_ready_timeout", 32'(bus.tlp_in_ready), 1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        bus.tlp_in_valid = 1'b0;
    endtask

    task automatic wait_dllps(input int max);
        int n;
        n = 0;
        while (exp_dllp.size() != 0 && n < max) begin
            @(negedge clk);
            n++;
        end
        idle(1);
        chk("dllp_drain", exp_dllp.size(), 0);
    endtask

    task automatic wait_valid(input int max);
        int n;
        n = 0;
        while (!bus.dllp_valid_o && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("wait_dllp_valid", 32'(bus.dllp_valid_o), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int base;
        bus.tlp_in_valid = 1'b0;
        bus.tlp_in_data = '0;
        bus.tlp_out_ready = 1'b1;
        bus.dllp_ready_i = 1'b1;

        // In-order seq 0..3 with an output stall, one coalesced ACK seq 3
        do_reset();
        set_out_ready(1'b0);
        send(0, 1'b0, 1'b1);
        @(negedge clk);
        chk("t1_stall_in_ready", 32'(bus.tlp_in_ready), 0);
        chk("t1_stall_out_valid", 32'(bus.tlp_out_valid), 1);
        idle(2);
        chk("t1_stall_hold", 32'(bus.tlp_in_ready), 0);
        set_out_ready(1'b1);
        base = n_dllp;
        exp_dllp.push_back(dl(0, 3));
        send(1, 1'b0, 1'b1);
        send(2, 1'b0, 1'b1);
        send(3, 1'b0, 1'b1);
        a = acc_cyc;
        wait_dllps(20);
        chk("t1_ack_latency", rise_cyc - a, 1);
        idle(80);
        chk("t1_one_ack", n_dllp - base, 1);
        chk("t1_tlp_drain", exp_tlp.size(), 0);

        // Single TLP: ACK forced out by the latency timer
        do_reset();
        exp_dllp.push_back(dl(0, 0));
        send(0, 1'b0, 1'b1);
        a = acc_cyc;
        wait_dllps(100);
        chk("t2_ack_timer", rise_cyc - a, 64);
        chk("t2_tlp_drain", exp_tlp.size(), 0);

        // Lost TLP: one NAK, no repeat, cleared by the next good TLP
        do_reset();
        exp_dllp.push_back(dl(1, 0));
        send(0, 1'b0, 1'b1);
        send(2, 1'b0, 1'b0);
        wait_dllps(20);
        base = n_dllp;
        send(3, 1'b0, 1'b0);
        idle(10);
        chk("t3_no_second_nak", n_dllp - base, 0);
        exp_dllp.push_back(dl(0, 1));
        send(1, 1'b0, 1'b1);
        wait_dllps(100);
        exp_dllp.push_back(dl(1, 1));
        send(3, 1'b0, 1'b0);
        wait_dllps(20);
        chk("t3_tlp_drain", exp_tlp.size(), 0);

        // LCRC errors: dropped, counted, only the first one NAKs
        do_reset();
        exp_dllp.push_back(dl(1, 12'hFFF));
        send(0, 1'b1, 1'b0);
        wait_dllps(20);
        chk("t4_err_cnt1", 32'(bus.lcrc_err_cnt), 1);
        base = n_dllp;
        send(0, 1'b1, 1'b0);
        idle(20);
        chk("t4_err_cnt2", 32'(bus.lcrc_err_cnt), 2);
        chk("t4_no_second_nak", n_dllp - base, 0);
        chk("t4_no_output", exp_tlp.size(), 0);

        // ACK held by back-pressure while a NAK event arrives
        do_reset();
        set_dllp_ready(1'b0);
        exp_dllp.push_back(dl(0, 3));
        exp_dllp.push_back(dl(1, 3));
        for (int i = 0; i < 4; i++) send(i, 1'b0, 1'b1);
        wait_valid(10);
        chk("t5_ack_first", bus.dllp_o, dl(0, 3));
        send(9, 1'b0, 1'b0);
        idle(10);
        chk("t5_ack_held", bus.dllp_o, dl(0, 3));
        set_dllp_ready(1'b1);
        wait_dllps(20);
        chk("t5_tlp_drain", exp_tlp.size(), 0);

        // Async reset while both valids are up
        do_reset();
        set_out_ready(1'b0);
        set_dllp_ready(1'b0);
        send(0, 1'b0, 1'b0);
        wait_valid(100);
        chk("t6_pre_out_valid", 32'(bus.tlp_out_valid), 1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_async_dllp_valid", 32'(bus.dllp_valid_o), 0);
        chk("t6_async_out_valid", 32'(bus.tlp_out_valid), 0);
        do_reset();
        base = n_dllp;
        idle(80);
        chk("t6_no_dllp_after", n_dllp - base, 0);

        // Sequence wrap over 4100 TLPs, then a duplicate re-ACK
        do_reset();
        wrap_mode = 1'b1;
        for (int i = 0; i < 4100; i++) send(i % 4096, 1'b0, 1'b1);
        idle(100);
        wrap_mode = 1'b0;
        chk("t7_wrap_drain", exp_tlp.size(), 0);
        exp_dllp.push_back(dl(0, 3));
        send(4095, 1'b0, 1'b0);
        wait_dllps(100);
        idle(5);
        chk("t7_dup_not_fwd", exp_tlp.size(), 0);
        chk("t7_err_cnt", 32'(bus.lcrc_err_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
